// File: rtl/test_result_monitor_if.sv
// Bus between a Core-side driver and the end-of-test monitor.
// master: drives run control and Core observations, reads the verdict.
// slave : the monitor itself.
interface test_result_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();
  logic             en;
  logic             clr;
  logic             pc_valid;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  gp;
  logic             st_valid;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_data;
  logic             done;
  logic             done_pulse;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [XLEN-2:0]  fail_test_num;
  logic [XLEN-1:0]  result_code;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output en, clr, pc_valid, pc, gp, st_valid, st_addr, st_data,
    input  done, done_pulse, pass, fail, timeout, fail_test_num, result_code, cycle_cnt
  );

  modport slave (
    input  en, clr, pc_valid, pc, gp, st_valid, st_addr, st_data,
    output done, done_pulse, pass, fail, timeout, fail_test_num, result_code, cycle_cnt
  );
endinterface

// File: rtl/test_result_monitor.sv
// End-of-test monitor for riscv-tests runs: watches the retired PC and gp (x3),
// declares PASS/FAIL once the PC parks at PASS_PC for HOLD_CYCLES consecutive
// cycles, or TIMEOUT when the cycle budget runs out.
// Optional feature macro: TOHOST_EN -- a store of an odd word to TOHOST_ADDR
// also yields a verdict (and wins over the PC rule in the same cycle).
module test_result_monitor #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PASS_PC     = 'h44,
  parameter int              HOLD_CYCLES = 2,
  parameter int              TIMEOUT     = 5000,
  parameter int              CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000
) (
  input logic                   clk,
  input logic                   rst,
  test_result_monitor_if.slave  mon
);

  localparam int               HW       = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_TGT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]    HOLD_ONE = HW'(1);
  localparam logic [CNT_W-1:0] TMO_TGT  = CNT_W'(TIMEOUT);
  localparam logic [XLEN-1:0]  V_PASS   = XLEN'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_MATCH, S_PASS, S_FAIL, S_TMO
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-2:0]   fail_test_num_q, fail_test_num_d;
  logic [XLEN-1:0]   result_code_q, result_code_d;

  logic              hit;
  logic              tohost_hit;
  logic [HW-1:0]     hold_next;
  logic              take_v;
  logic [XLEN-1:0]   v_word;

  // Saturating cycle counter increment
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit = mon.pc_valid && (mon.pc == PASS_PC);

`ifdef TOHOST_EN
  // Only odd words count as a verdict; even stores are ordinary traffic
  assign tohost_hit = mon.st_valid && (mon.st_addr == TOHOST_ADDR) && mon.st_data[0];
`else
  logic unused_st;
  assign unused_st  = mon.st_valid ^ (^mon.st_addr) ^ (^mon.st_data);
  assign tohost_hit = 1'b0;
`endif

  // Next-state, counters and verdict capture
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    cycle_cnt_d     = cycle_cnt_q;
    done_d          = done_q;
    done_pulse_d    = 1'b0;
    pass_d          = pass_q;
    fail_d          = fail_q;
    timeout_d       = timeout_q;
    fail_test_num_d = fail_test_num_q;
    result_code_d   = result_code_q;
    hold_next       = (state_q == S_MATCH) ? hold_cnt_q + HOLD_ONE : HOLD_ONE;
    take_v          = 1'b0;
    v_word          = mon.gp;

    if (mon.clr) begin
      state_d         = S_IDLE;
      hold_cnt_d      = '0;
      cycle_cnt_d     = '0;
      done_d          = 1'b0;
      pass_d          = 1'b0;
      fail_d          = 1'b0;
      timeout_d       = 1'b0;
      fail_test_num_d = '0;
      result_code_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mon.en) state_d = S_RUN;
        end
        S_RUN, S_MATCH: begin
          if (mon.en) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (tohost_hit) begin
              take_v = 1'b1;
              v_word = mon.st_data;
            end else if (hit && (hold_next == HOLD_TGT)) begin
              take_v = 1'b1;
              v_word = mon.gp;
            end

            if (take_v) begin
              hold_cnt_d    = '0;
              done_d        = 1'b1;
              done_pulse_d  = 1'b1;
              result_code_d = v_word;
              if (v_word == V_PASS) begin
                state_d = S_PASS;
                pass_d  = 1'b1;
              end else begin
                state_d         = S_FAIL;
                fail_d          = 1'b1;
                fail_test_num_d = v_word[XLEN-1:1];
              end
            end else if (cycle_cnt_d == TMO_TGT) begin
              state_d       = S_TMO;
              hold_cnt_d    = '0;
              done_d        = 1'b1;
              done_pulse_d  = 1'b1;
              timeout_d     = 1'b1;
              result_code_d = mon.gp;
            end else if (hit) begin
              state_d    = S_MATCH;
              hold_cnt_d = hold_next;
            end else begin
              state_d    = S_RUN;
              hold_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      hold_cnt_q      <= '0;
      cycle_cnt_q     <= '0;
      done_q          <= 1'b0;
      done_pulse_q    <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
      fail_test_num_q <= '0;
      result_code_q   <= '0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      cycle_cnt_q     <= cycle_cnt_d;
      done_q          <= done_d;
      done_pulse_q    <= done_pulse_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
      fail_test_num_q <= fail_test_num_d;
      result_code_q   <= result_code_d;
    end
  end

  assign mon.done          = done_q;
  assign mon.done_pulse    = done_pulse_q;
  assign mon.pass          = pass_q;
  assign mon.fail          = fail_q;
  assign mon.timeout       = timeout_q;
  assign mon.fail_test_num = fail_test_num_q;
  assign mon.result_code   = result_code_q;
  assign mon.cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor (TIMEOUT=20, HOLD_CYCLES=2).
module tb_test_result_monitor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  test_result_monitor_if #(.XLEN(32), .CNT_W(32)) mif ();

  test_result_monitor #(.TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n edges; outputs are sampled 1ns after the last edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pc(input logic v, input logic [31:0] p, input logic [31:0] g);
    mif.pc_valid = v;
    mif.pc       = p;
    mif.gp       = g;
  endtask

  task automatic do_clr();
    mif.clr = 1'b1;
    tick(1);
    mif.clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mif.en = 1'b0; mif.clr = 1'b0;
    mif.st_valid = 1'b0; mif.st_addr = '0; mif.st_data = '0;
    drive_pc(1'b0, 32'h0, 32'h0);
    tick(2);
    rst = 1'b0;

    // reset state
    chk("rst_done", mif.done, 0);
    chk("rst_pass", mif.pass, 0);
    chk("rst_result", mif.result_code, 0);
    chk("rst_cnt", mif.cycle_cnt, 0);

    // 1: walk to 0x44, hold two cycles, gp=1 -> PASS
    mif.en = 1'b1;
    tick(1);                                 // IDLE -> RUN
    chk("t1_idle_cnt", mif.cycle_cnt, 0);
    drive_pc(1'b1, 32'h3c, 32'h1); tick(1);
    drive_pc(1'b1, 32'h40, 32'h1); tick(1);
    drive_pc(1'b1, 32'h44, 32'h1); tick(1);  // MATCH, hold=1
    chk("t1_no_early", mif.done, 0);
    tick(1);                                 // verdict
    chk("t1_pass", mif.pass, 1);
    chk("t1_fail", mif.fail, 0);
    chk("t1_done", mif.done, 1);
    chk("t1_pulse", mif.done_pulse, 1);
    chk("t1_result", mif.result_code, 1);
    chk("t1_cnt", mif.cycle_cnt, 4);
    drive_pc(1'b1, 32'h0, 32'h9); tick(1);
    chk("t1_pulse_end", mif.done_pulse, 0);
    chk("t1_sticky", mif.pass, 1);
    chk("t1_cnt_frozen", mif.cycle_cnt, 4);

    // 5a: clr from terminal PASS
    do_clr();
    chk("clr_pass", mif.pass, 0);
    chk("clr_done", mif.done, 0);
    chk("clr_result", mif.result_code, 0);
    chk("clr_cnt", mif.cycle_cnt, 0);

    // 2: hold at 0x44 with gp=7 -> FAIL, test 3
    drive_pc(1'b1, 32'h44, 32'h7);
    tick(1);                                 // IDLE -> RUN
    tick(1);                                 // MATCH
    chk("t2_no_early", mif.fail, 0);
    tick(1);
    chk("t2_fail", mif.fail, 1);
    chk("t2_pass", mif.pass, 0);
    chk("t2_ftn", mif.fail_test_num, 3);
    chk("t2_result", mif.result_code, 7);
    chk("t2_cnt", mif.cycle_cnt, 2);
    do_clr();
    chk("t2_clr_ftn", mif.fail_test_num, 0);

    // 3: single-cycle visit, leave, return for two cycles
    drive_pc(1'b1, 32'h10, 32'h1); tick(1);  // RUN
    drive_pc(1'b1, 32'h44, 32'h1); tick(1);  // MATCH cnt1
    drive_pc(1'b1, 32'h48, 32'h1); tick(1);  // back to RUN cnt2
    drive_pc(1'b1, 32'h44, 32'h1); tick(1);  // MATCH cnt3
    chk("t3_no_verdict", mif.done, 0);
    tick(1);
    chk("t3_pass", mif.pass, 1);
    chk("t3_pulse", mif.done_pulse, 1);
    chk("t3_cnt", mif.cycle_cnt, 4);
    do_clr();

    // 4: never hit, 5-cycle pause -> timeout after 20 counted cycles
    drive_pc(1'b1, 32'h10, 32'hdead);
    tick(1);                                 // RUN
    tick(10);
    chk("t4_cnt10", mif.cycle_cnt, 10);
    mif.en = 1'b0;
    tick(5);
    chk("t4_paused_cnt", mif.cycle_cnt, 10);
    chk("t4_paused_tmo", mif.timeout, 0);
    mif.en = 1'b1;
    tick(9);
    chk("t4_cnt19", mif.cycle_cnt, 19);
    chk("t4_not_yet", mif.timeout, 0);
    tick(1);
    chk("t4_tmo", mif.timeout, 1);
    chk("t4_cnt20", mif.cycle_cnt, 20);
    chk("t4_result", mif.result_code, 32'hdead);
    chk("t4_pulse", mif.done_pulse, 1);
    chk("t4_no_pass", mif.pass, 0);
    do_clr();

    // 5b: rst mid-MATCH clears at once
    drive_pc(1'b1, 32'h44, 32'h1);
    tick(1);                                 // RUN
    tick(1);                                 // MATCH cnt1
    chk("t5_pre_cnt", mif.cycle_cnt, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_cnt", mif.cycle_cnt, 0);
    chk("t5_rst_done", mif.done, 0);
    tick(1);
    rst = 1'b0;

    // 6: store to tohost on the same cycle as a PC verdict with gp=1
    tick(1);                                 // RUN
    tick(1);                                 // MATCH
    mif.st_valid = 1'b1; mif.st_addr = 32'h1000; mif.st_data = 32'h5;
    tick(1);
    mif.st_valid = 1'b0;
`ifdef TOHOST_EN
    chk("t6_fail", mif.fail, 1);
    chk("t6_ftn", mif.fail_test_num, 2);
    chk("t6_result", mif.result_code, 5);
`else
    chk("t6_pass", mif.pass, 1);
    chk("t6_fail", mif.fail, 0);
    chk("t6_result", mif.result_code, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
